// File: rtl/ltc2308_sampler.sv
// LTC2308 serial front-end: round-robin conversions over ch_mask, tagged samples on a valid/ready stream.
// Define LTC2308_SAMPLER_FIFO_EN to replace the single output register with a 4-entry FIFO.

module ltc2308_sampler #(
    parameter int CLK_DIV     = 2,
    parameter int CONV_CYCLES = 80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  ch_mask,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic [11:0] sample_data,
    output logic [2:0]  sample_ch,
    output logic        overrun,
    input  logic        overrun_clr
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CONV  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam int CW = 16;

    logic [1:0]    state_r;
    logic [2:0]    ch_r;
    logic [2:0]    prev_ch_r;
    logic [2:0]    next_ch_s;
    logic [CW-1:0] cnt_r;
    logic [3:0]    bit_r;
    logic [11:0]   shreg_r;
    logic          primed_r;
    logic          convst_r;
    logic          sck_r;
    logic          sdi_r;
    logic          start_s;
    logic          push_s;
    logic          drop_s;
    logic          overrun_r;

    // Next enabled channel above cur, ascending with wrap; cur itself if it is the only one.
    function automatic logic [2:0] next_channel(input logic [2:0] cur, input logic [7:0] mask);
        logic [2:0] idx;
        logic       found;
        next_channel = cur;
        found        = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = cur + 3'(i);
            if (!found && mask[idx]) begin
                next_channel = idx;
                found        = 1'b1;
            end
        end
    endfunction

    // SDI value for a bit slot: 6-bit config word MSB first, then zeros.
    function automatic logic cfg_bit(input logic [2:0] ch, input logic [3:0] idx);
        logic [5:0] word;
        word = {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
        if (idx < 4'd6) begin
            cfg_bit = word[3'd5 - idx[2:0]];
        end else begin
            cfg_bit = 1'b0;
        end
    endfunction

    // Frame start condition, channel advance and result push strobe.
    always_comb begin
        start_s   = enable && (ch_mask != 8'h00);
        next_ch_s = next_channel(ch_r, ch_mask);
        push_s    = (state_r == S_DONE) && primed_r;
    end

    // Frame sequencer driving the registered ADC pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= S_IDLE;
            ch_r      <= 3'd7;
            prev_ch_r <= 3'd0;
            cnt_r     <= '0;
            bit_r     <= 4'd0;
            shreg_r   <= 12'd0;
            primed_r  <= 1'b0;
            convst_r  <= 1'b0;
            sck_r     <= 1'b0;
            sdi_r     <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    primed_r <= 1'b0;
                    if (start_s) begin
                        state_r   <= S_CONV;
                        prev_ch_r <= ch_r;
                        ch_r      <= next_ch_s;
                        cnt_r     <= '0;
                        convst_r  <= 1'b1;
                    end
                end
                S_CONV: begin
                    if (cnt_r == CW'(CONV_CYCLES - 1)) begin
                        state_r  <= S_SHIFT;
                        convst_r <= 1'b0;
                        cnt_r    <= '0;
                        bit_r    <= 4'd0;
                        sck_r    <= 1'b0;
                        sdi_r    <= cfg_bit(ch_r, 4'd0);
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                S_SHIFT: begin
                    // SDO is captured on the same edge that raises SCK
                    if (cnt_r == CW'(CLK_DIV - 1)) begin
                        sck_r   <= 1'b1;
                        shreg_r <= {shreg_r[10:0], adc_sdo};
                        cnt_r   <= cnt_r + CW'(1);
                    end else if (cnt_r == CW'(2 * CLK_DIV - 1)) begin
                        sck_r <= 1'b0;
                        cnt_r <= '0;
                        if (bit_r == 4'd11) begin
                            state_r <= S_DONE;
                            sdi_r   <= 1'b0;
                        end else begin
                            bit_r <= bit_r + 4'd1;
                            sdi_r <= cfg_bit(ch_r, bit_r + 4'd1);
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                S_DONE: begin
                    primed_r <= 1'b1;
                    if (start_s) begin
                        state_r   <= S_CONV;
                        prev_ch_r <= ch_r;
                        ch_r      <= next_ch_s;
                        cnt_r     <= '0;
                        convst_r  <= 1'b1;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign adc_convst = convst_r;
    assign adc_sck    = sck_r;
    assign adc_sdi    = sdi_r;

`ifdef LTC2308_SAMPLER_FIFO_EN
    logic [14:0] mem_r [4];
    logic [1:0]  wr_r;
    logic [1:0]  rd_r;
    logic [2:0]  count_r;
    logic        pop_s;
    logic        wr_en_s;

    // A full FIFO still accepts a push when an entry leaves in the same cycle.
    always_comb begin
        pop_s   = (count_r != 3'd0) && sample_ready;
        drop_s  = push_s && (count_r == 3'd4) && !pop_s;
        wr_en_s = push_s && !drop_s;
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                mem_r[i] <= 15'd0;
            end
            wr_r    <= 2'd0;
            rd_r    <= 2'd0;
            count_r <= 3'd0;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_r] <= {shreg_r, prev_ch_r};
                wr_r        <= wr_r + 2'd1;
            end
            if (pop_s) begin
                rd_r <= rd_r + 2'd1;
            end
            count_r <= count_r + {2'b00, wr_en_s} - {2'b00, pop_s};
        end
    end

    assign sample_valid = (count_r != 3'd0);
    assign sample_data  = mem_r[rd_r][14:3];
    assign sample_ch    = mem_r[rd_r][2:0];
`else
    logic        valid_r;
    logic [11:0] data_r;
    logic [2:0]  sch_r;

    // Single entry: a push lands if the slot is free or being emptied this cycle.
    always_comb begin
        drop_s = push_s && valid_r && !sample_ready;
    end

    // Output holding register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= 1'b0;
            data_r  <= 12'd0;
            sch_r   <= 3'd0;
        end else if (push_s && !drop_s) begin
            valid_r <= 1'b1;
            data_r  <= shreg_r;
            sch_r   <= prev_ch_r;
        end else if (valid_r && sample_ready) begin
            valid_r <= 1'b0;
        end
    end

    assign sample_valid = valid_r;
    assign sample_data  = data_r;
    assign sample_ch    = sch_r;
`endif

    // Sticky overrun; a new drop outranks a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_r <= 1'b0;
        end else if (drop_s) begin
            overrun_r <= 1'b1;
        end else if (overrun_clr) begin
            overrun_r <= 1'b0;
        end
    end

    assign overrun = overrun_r;

endmodule

// File: tb/tb_ltc2308_sampler.sv
// Directed bench for ltc2308_sampler with an LTC2308 pin model and a sample scoreboard.
module tb_ltc2308_sampler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  ch_mask = 8'h00;
    logic        adc_convst, adc_sck, adc_sdi;
    logic        adc_sdo = 1'b0;
    logic        sample_valid;
    logic        sample_ready = 1'b0;
    logic [11:0] sample_data;
    logic [2:0]  sample_ch;
    logic        overrun;
    logic        overrun_clr = 1'b0;

`ifdef LTC2308_SAMPLER_FIFO_EN
    localparam int NPUSH = 6;
    localparam int HELD  = 4;
`else
    localparam int NPUSH = 3;
    localparam int HELD  = 1;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int conv_rises = 0;
    int conv_falls = 0;
    int conv_start = 0;
    int sck_k = 0;
    int last_sck = 0;
    int last_hs = -1;
    int snap;
    bit chk_cfg = 1'b0;
    bit chk_int = 1'b0;
    bit cfg_seen = 1'b0;
    logic [5:0]  sdi_sh = 6'd0;
    logic [2:0]  cfg_ch = 3'd0;
    logic [11:0] conv_word = 12'd0;
    logic [14:0] exp_q [$];
    logic [14:0] e;

    ltc2308_sampler dut (
        .clk(clk), .reset(reset), .enable(enable), .ch_mask(ch_mask),
        .adc_convst(adc_convst), .adc_sck(adc_sck), .adc_sdi(adc_sdi), .adc_sdo(adc_sdo),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sample_data(sample_data), .sample_ch(sample_ch),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [11:0] chval(input logic [2:0] c);
        case (c)
            3'd0:    chval = 12'hA5A;
            3'd1:    chval = 12'h3C7;
            3'd2:    chval = 12'h123;
            default: chval = {9'h100, c};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ADC model: conversion uses the channel configured during the previous frame.
    always @(posedge adc_convst) begin
        if (chk_cfg) check("sck_pulses", sck_k, 12);
        conv_rises++;
        conv_start = cyc;
        conv_word  = cfg_seen ? chval(cfg_ch) : 12'h000;
        sck_k      = 0;
        adc_sdo    = conv_word[11];
    end

    always @(negedge adc_convst) begin
        conv_falls++;
        if (chk_cfg) check("convst_width", cyc - conv_start, 80);
    end

    always @(posedge adc_sck) begin
        if (chk_cfg && sck_k > 0) check("sck_period", cyc - last_sck, 4);
        last_sck = cyc;
        if (sck_k < 6) sdi_sh = {sdi_sh[4:0], adc_sdi};
        sck_k++;
        if (sck_k == 6) begin
            cfg_ch   = {sdi_sh[3], sdi_sh[2], sdi_sh[4]};
            cfg_seen = 1'b1;
            if (chk_cfg) check("cfg_word", sdi_sh, 6'b110010);
        end
        adc_sdo = (sck_k < 12) ? conv_word[11 - sck_k] : 1'b0;
    end

    // Scoreboard: every accepted sample must match the next expected entry.
    always @(negedge clk) begin
        if (!reset && sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_sample", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("sample_ch", sample_ch, e[14:12]);
                check("sample_data", sample_data, e[11:0]);
            end
            if (chk_int && last_hs >= 0) check("sample_interval", cyc - last_hs, 129);
            last_hs = chk_int ? cyc : -1;
        end
    end

    task automatic wait_conv_end(input string tag);
        int target;
        target = conv_falls + 1;
        for (int i = 0; i < 400 && conv_falls < target; i++) @(posedge clk);
        check({"conv_end_", tag}, conv_falls >= target, 1);
    endtask

    task automatic wait_q(input string tag, input int left, input int budget);
        for (int i = 0; i < budget && exp_q.size() > left; i++) @(posedge clk);
        check({"queue_", tag}, exp_q.size(), left);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_convst", adc_convst, 0);
        check("rst_sck", adc_sck, 0);
        check("rst_sdi", adc_sdi, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_data", {sample_ch, sample_data}, 0);
        reset = 1'b0;

        // Round robin over CH0/CH2, first frame discarded, one sample per frame
        ch_mask = 8'h05; sample_ready = 1'b1; chk_int = 1'b1;
        exp_q.push_back({3'd0, 12'hA5A}); exp_q.push_back({3'd2, 12'h123});
        exp_q.push_back({3'd0, 12'hA5A}); exp_q.push_back({3'd2, 12'h123});
        exp_q.push_back({3'd0, 12'hA5A});
        enable = 1'b1;
        wait_q("rr4", 1, 1000);
        enable = 1'b0;
        wait_q("rr5", 0, 300);
        chk_int = 1'b0;
        snap = conv_rises;
        repeat (300) @(posedge clk);
        #1;
        check("idle_after_rr", conv_rises - snap, 0);

        // Config word / pin timing on CH1; enable dropped at SHIFT bit 5 of frame 4
        ch_mask = 8'h02; chk_cfg = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back({3'd1, 12'h3C7});
        enable = 1'b1;
        wait_conv_end("f1"); wait_conv_end("f2"); wait_conv_end("f3"); wait_conv_end("f4");
        repeat (21) @(posedge clk);
        #1;
        enable = 1'b0;
        wait_q("cfg", 0, 300);
        snap = conv_rises;
        repeat (300) @(posedge clk);
        #1;
        chk_cfg = 1'b0;
        check("idle_after_drop", conv_rises - snap, 0);
        check("idle_sck", adc_sck, 0);

        // Re-enable: first frame after idle is discarded
        sample_ready = 1'b0; enable = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check("reenable_discard", sample_valid, 0);
        enable = 1'b0;
        exp_q.push_back({3'd1, 12'h3C7});
        sample_ready = 1'b1;
        wait_q("reenable", 0, 300);

        // Backpressure: storage fills, later pushes dropped, clear loses to a same-cycle overrun
        sample_ready = 1'b0; ch_mask = 8'h05; enable = 1'b1;
        wait_conv_end("bp0");
        for (int p = 1; p <= NPUSH; p++) begin
            wait_conv_end("bp");
            if (p == NPUSH) enable = 1'b0;
            repeat (47) @(posedge clk);
            #1;
            if (p == NPUSH) overrun_clr = 1'b1;
            @(posedge clk);
            #1;
            overrun_clr = 1'b0;
            check("bp_valid", sample_valid, 1);
            check("bp_overrun", overrun, (p > HELD));
        end
        @(posedge clk);
        #1;
        check("overrun_sticky", overrun, 1);
        overrun_clr = 1'b1;
        @(posedge clk);
        #1;
        overrun_clr = 1'b0;
        check("overrun_cleared", overrun, 0);
        for (int i = 0; i < HELD; i++) begin
            if (i % 2 == 0) exp_q.push_back({3'd2, 12'h123});
            else exp_q.push_back({3'd0, 12'hA5A});
        end
        sample_ready = 1'b1;
        wait_q("bp_drain", 0, 50);
        repeat (5) @(posedge clk);
        #1;
        check("bp_empty", sample_valid, 0);

        // Reset pulsed mid-SHIFT with a sample pending
        sample_ready = 1'b0; ch_mask = 8'h01; enable = 1'b1;
        wait_conv_end("r1"); wait_conv_end("r2"); wait_conv_end("r3");
        @(posedge clk);
        #2;
        check("pre_rst_sck", adc_sck, 1);
        check("pre_rst_sdi", adc_sdi, 1);
        check("pre_rst_valid", sample_valid, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_sck", adc_sck, 0);
        check("mid_rst_convst", adc_convst, 0);
        check("mid_rst_sdi", adc_sdi, 0);
        check("mid_rst_valid", sample_valid, 0);
        @(posedge clk);
        #1;
        enable = 1'b0; reset = 1'b0; sample_ready = 1'b1;
        snap = conv_rises;
        repeat (300) @(posedge clk);
        #1;
        check("post_rst_idle", conv_rises - snap, 0);
        check("post_rst_valid", sample_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
